// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default sizes and FSM encodings.
package instr_fetch_unit_pkg;

  localparam int IFU_WIDTH   = 16;
  localparam int IFU_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_DRAIN = 2'b10
  } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// Cycle counter bounding how long a memory request may stay outstanding.
module fetch_timeout_ctr
  import instr_fetch_unit_pkg::*;
#(
  parameter int TIMEOUT = IFU_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches the instruction at PC over a held req/ack memory port and latches it into IR.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int WIDTH   = IFU_WIDTH,
  parameter int TIMEOUT = IFU_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  input  logic             fetch,
  input  logic             flush,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_req,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] ir,
  output logic             ir_valid,
  output logic [WIDTH-1:0] next_pc,
  output logic             busy,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  ifu_state_t state_reg;
  logic       tmo_clear;
  logic       tmo_enable;
  logic       tmo_expired;

  // Counter rests at zero in IDLE; a flush cycle in WAIT does not advance it.
  assign tmo_clear  = (state_reg == ST_IDLE);
  assign tmo_enable = !mem_ack &&
                      (((state_reg == ST_WAIT) && !flush) || (state_reg == ST_DRAIN));

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      mem_addr  <= '0;
      mem_req   <= 1'b0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      next_pc   <= ONE;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (flush) begin
            ir_valid <= 1'b0;
          end else if (fetch) begin
            mem_addr  <= pc;
            mem_req   <= 1'b1;
            ir_valid  <= 1'b0;
            busy      <= 1'b1;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            if (!flush) begin
              ir       <= mem_data;
              ir_valid <= 1'b1;
              next_pc  <= mem_addr + ONE;
            end
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (flush) begin
            // Keep the request up so the memory can finish its handshake.
            ir_valid  <= 1'b0;
            state_reg <= ST_DRAIN;
          end else if (tmo_expired) begin
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (tmo_expired) begin
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          mem_req   <= 1'b0;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a scoreboard of expected IR/NEXT_PC loads.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        fetch;
  logic        flush;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic [15:0] ir;
  logic        ir_valid;
  logic [15:0] next_pc;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] next_pc;
  } exp_t;

  exp_t exp_q[$];

  instr_fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .fetch    (fetch),
    .flush    (flush),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_data (mem_data),
    .mem_ack  (mem_ack),
    .ir       (ir),
    .ir_valid (ir_valid),
    .next_pc  (next_pc),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every rising IR_VALID must match the oldest queued expectation.
  logic ir_valid_prev = 1'b0;
  always @(negedge clk) begin
    if (ir_valid && !ir_valid_prev) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_load", {16'h0, ir}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("fetch done: ir=%04h next_pc=%04h (expected %04h/%04h)", ir, next_pc, e.ir, e.next_pc);
        chk("sb_ir", {16'h0, ir}, {16'h0, e.ir});
        chk("sb_next_pc", {16'h0, next_pc}, {16'h0, e.next_pc});
      end
    end
    ir_valid_prev = ir_valid;
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_mem_req"},  {31'h0, mem_req}, 32'h0);
    chk({tag, "_mem_addr"}, {16'h0, mem_addr}, 32'h0);
    chk({tag, "_ir"},       {16'h0, ir}, 32'h0);
    chk({tag, "_ir_valid"}, {31'h0, ir_valid}, 32'h0);
    chk({tag, "_next_pc"},  {16'h0, next_pc}, 32'h1);
    chk({tag, "_busy"},     {31'h0, busy}, 32'h0);
    chk({tag, "_err"},      {31'h0, err}, 32'h0);
  endtask

  // Issue a fetch of addr, answered by an ACK on the next edge with data.
  task automatic quick_fetch(input logic [15:0] addr, input logic [15:0] data);
    pc    = addr;
    fetch = 1'b1;
    exp_q.push_back({data, addr + 16'h1});
    tick();
    chk("qf_req", {31'h0, mem_req}, 32'h1);
    chk("qf_addr", {16'h0, mem_addr}, {16'h0, addr});
    fetch    = 1'b0;
    mem_ack  = 1'b1;
    mem_data = data;
    tick();
    mem_ack  = 1'b0;
    chk("qf_req_drop", {31'h0, mem_req}, 32'h0);
    chk("qf_busy", {31'h0, busy}, 32'h0);
    chk("qf_ir_valid", {31'h0, ir_valid}, 32'h1);
    chk("qf_ir", {16'h0, ir}, {16'h0, data});
  endtask

  initial begin
    int cnt;
    reset = 1'b0; pc = 16'h0; fetch = 1'b1; flush = 1'b0;
    mem_data = 16'h0; mem_ack = 1'b0;

    // 1. reset dominates a pending FETCH
    tick();
    tick();
    check_reset_state("rst");
    reset = 1'b1;
    fetch = 1'b0;
    tick();
    chk("rst_idle_req", {31'h0, mem_req}, 32'h0);

    // 2. basic two-cycle fetch
    quick_fetch(16'd12, 16'h1234);
    chk("basic_next_pc", {16'h0, next_pc}, 32'd13);

    // 3. slow memory; FETCH while busy is ignored
    pc    = 16'h0040;
    fetch = 1'b1;
    exp_q.push_back({16'hCAFE, 16'h0041});
    tick();
    for (int i = 0; i < 5; i++) begin
      fetch = (i == 2);
      pc    = (i == 2) ? 16'h0099 : 16'h0040;
      tick();
      chk("slow_req_held", {31'h0, mem_req}, 32'h1);
      chk("slow_addr_held", {16'h0, mem_addr}, 32'h0040);
    end
    fetch    = 1'b0;
    mem_ack  = 1'b1;
    mem_data = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    chk("slow_ir", {16'h0, ir}, 32'hCAFE);
    chk("slow_next_pc", {16'h0, next_pc}, 32'h0041);
    tick();
    chk("slow_no_second_req", {31'h0, mem_req}, 32'h0);

    // 4. flush while waiting: drain the request, discard data
    pc    = 16'd20;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {31'h0, busy}, 32'h1);
    chk("flush_req_held", {31'h0, mem_req}, 32'h1);
    chk("flush_addr_held", {16'h0, mem_addr}, 32'd20);
    chk("flush_ir_valid", {31'h0, ir_valid}, 32'h0);
    tick();
    chk("drain_req_held", {31'h0, mem_req}, 32'h1);
    mem_ack  = 1'b1;
    mem_data = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    chk("drain_req_drop", {31'h0, mem_req}, 32'h0);
    chk("drain_busy", {31'h0, busy}, 32'h0);
    chk("drain_ir_valid", {31'h0, ir_valid}, 32'h0);
    chk("drain_ir_kept", {16'h0, ir}, 32'hCAFE);

    // 5. timeout: request drops after 15 WAIT cycles, ERR sticky
    pc    = 16'd7;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    cnt = mem_req ? 1 : 0;
    for (int i = 0; i < 40 && mem_req; i++) begin
      tick();
      if (mem_req) cnt++;
    end
    chk("timeout_cycles", cnt, 32'd15);
    chk("timeout_err", {31'h0, err}, 32'h1);
    chk("timeout_busy", {31'h0, busy}, 32'h0);
    chk("timeout_ir_valid", {31'h0, ir_valid}, 32'h0);
    quick_fetch(16'd3, 16'h5A5A);
    chk("after_err_next_pc", {16'h0, next_pc}, 32'd4);
    chk("err_sticky", {31'h0, err}, 32'h1);

    // 6. address wrap, then reset in the middle of a request
    quick_fetch(16'hFFFF, 16'h1111);
    chk("wrap_next_pc", {16'h0, next_pc}, 32'h0);
    pc    = 16'h0030;
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b0;
    tick();
    check_reset_state("midrst");
    reset = 1'b1;
    tick();
    quick_fetch(16'h0100, 16'h7777);
    chk("recover_next_pc", {16'h0, next_pc}, 32'h0101);

    tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
